// File: rtl/obs_render.sv
// ============================================================================
// obs_render : obstacle sequencer (spawn/scroll/retire) and sprite-fetch front end
// Option macro: OBS_RENDER_BIRDS_EN (bird types with lifted y).  Rev 1.0
// ============================================================================
`default_nettype none

module obs_render #(
   parameter int H_BITS        = 10,
   parameter int SCREEN_W      = 640,
   parameter int GROUND_Y      = 400,
   parameter int SCALE_SHIFT   = 3,
   parameter int BIRD_LOW_OFF  = 24,
   parameter int BIRD_HIGH_OFF = 56
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_frame_tick,
   input  logic              i_game_run,
   input  logic              i_clear,
   input  logic [3:0]        i_speed,
   input  logic [H_BITS-1:0] i_hpos,
   input  logic [H_BITS-1:0] i_vpos,
   input  logic              i_sprite_color,
   output logic [2:0]        o_rom_counter,
   output logic [2:0]        o_obs_type,
   output logic              o_obs_pixel,
   output logic [H_BITS-1:0] o_obs_x,
   output logic [H_BITS-1:0] o_obs_y,
   output logic              o_spawn
);

   localparam logic [0:0] ST_GAP    = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   localparam int SPR_W = 2 << SCALE_SHIFT;
   localparam int SPR_H = 4 << SCALE_SHIFT;
   localparam int ROM_PX = 1 << SCALE_SHIFT;

   localparam logic [H_BITS-1:0] X_SPAWN   = H_BITS'(SCREEN_W);
   localparam logic [H_BITS-1:0] Y_CACTUS  = H_BITS'(GROUND_Y - SPR_H);
   localparam logic [2:0]        T_EMPTY   = 3'b000;
   localparam logic [4:0]        GAP_INIT  = 5'd8;
   localparam logic [4:0]        GAP_BASE  = 5'd16;
   localparam logic [7:0]        LFSR_SEED = 8'hA5;

   logic [0:0]        state_q, state_d;
   logic [4:0]        gap_cnt_q, gap_cnt_d;
   logic [H_BITS-1:0] x_q, x_d;
   logic [2:0]        type_q, type_d;
   logic [7:0]        lfsr_q, lfsr_d;
   logic              spawn_q, spawn_d;
   logic              pixel_q, pixel_d;

   logic [7:0]        lfsr_step;
   logic [2:0]        spawn_type;
   logic [H_BITS-1:0] speed_ext;
   logic [H_BITS-1:0] y_top;

   logic [H_BITS:0]   hpos_e, vpos_e, x_lo, x_mid, x_hi;
   logic [H_BITS:0]   y_lo, y_q1, y_q2, y_q3, y_hi;
   logic              in_box;

   // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
   assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign speed_ext = {{(H_BITS-4){1'b0}}, i_speed};

`ifdef OBS_RENDER_BIRDS_EN
   localparam logic [H_BITS-1:0] Y_BIRD_LOW  = H_BITS'(GROUND_Y - SPR_H - BIRD_LOW_OFF);
   localparam logic [H_BITS-1:0] Y_BIRD_HIGH = H_BITS'(GROUND_Y - SPR_H - BIRD_HIGH_OFF);

   always_comb begin
      spawn_type = lfsr_q[2:0];
      if (lfsr_q[2:0] == T_EMPTY) begin
         spawn_type = 3'b001;
      end
   end

   always_comb begin
      case (type_q)
         3'b110:  y_top = Y_BIRD_LOW;
         3'b111:  y_top = Y_BIRD_HIGH;
         default: y_top = Y_CACTUS;
      endcase
   end
`else
   // Bird codes fold onto cactus codes so only ground-level sprites appear
   always_comb begin
      case (lfsr_q[2:0])
         3'b000:  spawn_type = 3'b001;
         3'b110:  spawn_type = 3'b010;
         3'b111:  spawn_type = 3'b011;
         default: spawn_type = lfsr_q[2:0];
      endcase
   end

   assign y_top = Y_CACTUS;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_GAP;
         gap_cnt_q <= GAP_INIT;
         x_q       <= X_SPAWN;
         type_q    <= T_EMPTY;
         lfsr_q    <= LFSR_SEED;
         spawn_q   <= 1'b0;
         pixel_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         x_q       <= x_d;
         type_q    <= type_d;
         lfsr_q    <= lfsr_d;
         spawn_q   <= spawn_d;
         pixel_q   <= pixel_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      x_d       = x_q;
      type_d    = type_q;
      lfsr_d    = lfsr_q;
      spawn_d   = 1'b0;
      if (i_clear) begin
         state_d   = ST_GAP;
         gap_cnt_d = GAP_INIT;
         x_d       = X_SPAWN;
         type_d    = T_EMPTY;
         lfsr_d    = LFSR_SEED;
      end else if (i_frame_tick && i_game_run) begin
         lfsr_d = lfsr_step;
         case (state_q)
            ST_GAP: begin
               if (gap_cnt_q == 5'd0) begin
                  state_d = ST_ACTIVE;
                  x_d     = X_SPAWN;
                  type_d  = spawn_type;
                  spawn_d = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q - 5'd1;
               end
            end
            default: begin
               if (x_q < speed_ext) begin
                  state_d   = ST_GAP;
                  type_d    = T_EMPTY;
                  gap_cnt_d = GAP_BASE + {1'b0, lfsr_q[7:4]};
               end else begin
                  x_d = x_q - speed_ext;
               end
            end
         endcase
      end
   end

   // Box edges at one extra bit so a sprite at the right screen edge cannot wrap;
   // ROM column/row come from comparisons against the scaled-pixel boundaries.
   always_comb begin
      hpos_e = {1'b0, i_hpos};
      vpos_e = {1'b0, i_vpos};
      x_lo   = {1'b0, x_q};
      x_mid  = x_lo + (H_BITS+1)'(ROM_PX);
      x_hi   = x_lo + (H_BITS+1)'(SPR_W);
      y_lo   = {1'b0, y_top};
      y_q1   = y_lo + (H_BITS+1)'(ROM_PX);
      y_q2   = y_lo + (H_BITS+1)'(2 * ROM_PX);
      y_q3   = y_lo + (H_BITS+1)'(3 * ROM_PX);
      y_hi   = y_lo + (H_BITS+1)'(SPR_H);
      in_box = (type_q != T_EMPTY) &&
               (hpos_e >= x_lo) && (hpos_e < x_hi) &&
               (vpos_e >= y_lo) && (vpos_e < y_hi);
      o_rom_counter = 3'b000;
      if (in_box) begin
         o_rom_counter = {(vpos_e >= y_q2),
                          ((vpos_e >= y_q1) && (vpos_e < y_q2)) || (vpos_e >= y_q3),
                          (hpos_e >= x_mid)};
      end
      pixel_d = in_box & i_sprite_color;
   end

   assign o_obs_type  = type_q;
   assign o_obs_pixel = pixel_q;
   assign o_obs_x     = x_q;
   assign o_obs_y     = y_top;
   assign o_spawn     = spawn_q;

endmodule

`default_nettype wire

// File: tb/tb_obs_render.sv
// ============================================================================
// tb_obs_render : directed scoreboard bench for obs_render.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_obs_render;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_frame_tick = 1'b0;
   logic       i_game_run = 1'b0;
   logic       i_clear = 1'b0;
   logic [3:0] i_speed = 4'd0;
   logic [9:0] i_hpos = 10'd0;
   logic [9:0] i_vpos = 10'd0;
   logic       i_sprite_color = 1'b0;
   logic [2:0] o_rom_counter;
   logic [2:0] o_obs_type;
   logic       o_obs_pixel;
   logic [9:0] o_obs_x;
   logic [9:0] o_obs_y;
   logic       o_spawn;

   obs_render dut (
      .clk            (clk),
      .rst            (rst),
      .i_frame_tick   (i_frame_tick),
      .i_game_run     (i_game_run),
      .i_clear        (i_clear),
      .i_speed        (i_speed),
      .i_hpos         (i_hpos),
      .i_vpos         (i_vpos),
      .i_sprite_color (i_sprite_color),
      .o_rom_counter  (o_rom_counter),
      .o_obs_type     (o_obs_type),
      .o_obs_pixel    (o_obs_pixel),
      .o_obs_x        (o_obs_x),
      .o_obs_y        (o_obs_y),
      .o_spawn        (o_spawn)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       spawn;
      logic [9:0] x;
      logic [2:0] typ;
      logic [9:0] y;
   } exp_t;

   exp_t exp_q[$];
   logic pix_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic       m_active;
   int         m_gap;
   int         m_x;
   logic [2:0] m_type;
   logic [7:0] m_lfsr;
   logic       m_spawn;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] lf_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [2:0] remap(input logic [2:0] t);
      if (t == 3'd0) return 3'd1;
`ifndef OBS_RENDER_BIRDS_EN
      if (t == 3'd6) return 3'd2;
      if (t == 3'd7) return 3'd3;
`endif
      return t;
   endfunction

   function automatic int ytop(input logic [2:0] t);
`ifdef OBS_RENDER_BIRDS_EN
      if (t == 3'd6) return 400 - 32 - 24;
      if (t == 3'd7) return 400 - 32 - 56;
`endif
      return 400 - 32;
   endfunction

   // raw LFSR low bits at the spawn that follows retiring now with lfsr l
   function automatic logic [2:0] spawn_bits_after_retire(input logic [7:0] l);
      logic [7:0] m = l;
      int steps = 17 + int'(l[7:4]);
      for (int k = 0; k < steps; k++) m = lf_next(m);
      return m[2:0];
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_gap    = 8;
      m_x      = 640;
      m_type   = 3'd0;
      m_lfsr   = 8'hA5;
      m_spawn  = 1'b0;
   endtask

   task automatic model_tick(input int spd, input logic clr);
      m_spawn = 1'b0;
      if (clr) begin
         model_reset();
      end else if (i_game_run) begin
         if (!m_active) begin
            if (m_gap == 0) begin
               m_active = 1'b1;
               m_x      = 640;
               m_type   = remap(m_lfsr[2:0]);
               m_spawn  = 1'b1;
            end else begin
               m_gap--;
            end
         end else if (m_x < spd) begin
            m_active = 1'b0;
            m_type   = 3'd0;
            m_gap    = 16 + int'(m_lfsr[7:4]);
         end else begin
            m_x -= spd;
         end
         m_lfsr = lf_next(m_lfsr);
      end
   endtask

   task automatic do_tick(input int spd, input logic clr);
      exp_t e;
      @(negedge clk);
      i_speed      = 4'(spd);
      i_frame_tick = 1'b1;
      i_clear      = clr;
      model_tick(spd, clr);
      e.spawn = m_spawn;
      e.x     = 10'(m_x);
      e.typ   = m_type;
      e.y     = 10'(ytop(m_type));
      exp_q.push_back(e);
      @(negedge clk);
      i_frame_tick = 1'b0;
      i_clear      = 1'b0;
      if (exp_q.size() == 0) begin
         chk("tick_queue_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk("tick_spawn", o_spawn, e.spawn);
         chk("tick_x", o_obs_x, e.x);
         chk("tick_type", o_obs_type, e.typ);
         chk("tick_y", o_obs_y, e.y);
      end
      @(negedge clk);
      chk("spawn_one_cycle", o_spawn, 0);
   endtask

   task automatic pix(input int h, input int v, input logic c);
      int  yt = ytop(m_type);
      bit  inb;
      int  cnt;
      @(negedge clk);
      i_hpos = 10'(h);
      i_vpos = 10'(v);
      i_sprite_color = c;
      inb = (m_type != 3'd0) && (h >= m_x) && (h < m_x + 16) && (v >= yt) && (v < yt + 32);
      cnt = inb ? (((((v - yt) >> 3) & 3) << 1) | (((h - m_x) >> 3) & 1)) : 0;
      pix_q.push_back(inb & c);
      #1;
      chk("rom_counter", o_rom_counter, cnt);
      chk("obs_type_out", o_obs_type, m_type);
      @(negedge clk);
      if (pix_q.size() == 0) chk("pix_queue_empty", 1, 0);
      else chk("obs_pixel", o_obs_pixel, pix_q.pop_front());
   endtask

   task automatic tick_until_spawn(input int spd);
      bit got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         do_tick(spd, 1'b0);
         got = m_spawn;
      end
      chk("spawn_within_bound", got, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_spawn"}, o_spawn, 0);
      chk({tag, "_type"}, o_obs_type, 0);
      chk({tag, "_counter"}, o_rom_counter, 0);
      chk({tag, "_pixel"}, o_obs_pixel, 0);
      chk({tag, "_x"}, o_obs_x, 640);
      chk({tag, "_y"}, o_obs_y, 368);
   endtask

   initial begin
      int dh[9] = '{8, 16, -1, 0, 15, 15, 7, 7, 3};
      int dv[9] = '{17, 17, 0, 0, 31, 31, -1, 32, 9};
      bit cc[9] = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
      bit found;
      model_reset();

      // asynchronous reset, observed without a clock edge
      #3 rst = 1'b1;
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      i_game_run = 1'b1;

      // nine ticks to the first spawn
      for (int k = 0; k < 9; k++) do_tick(6, 1'b0);
      chk("first_spawn_seen", m_spawn, 1);
      chk("spawn_type_nonzero", (o_obs_type != 3'd0), 1);

      // scroll to x = 200 and render
      for (int k = 0; k < 29; k++) do_tick(15, 1'b0);
      do_tick(5, 1'b0);
      chk("x_at_200", o_obs_x, 200);
      for (int k = 0; k < 9; k++) pix(200 + dh[k], ytop(m_type) + dv[k], cc[k]);

      // down to 100, then one speed-6 step
      do_tick(10, 1'b0);
      for (int k = 0; k < 6; k++) do_tick(15, 1'b0);
      do_tick(6, 1'b0);
      chk("x_at_94", o_obs_x, 94);

      // frozen: ticks ignored, rendering alive
      i_game_run = 1'b0;
      for (int k = 0; k < 10; k++) do_tick(6, 1'b0);
      pix(94, ytop(m_type), 1'b1);
      i_game_run = 1'b1;

      // retire from x = 5 at speed 6, then wait out the gap
      for (int k = 0; k < 5; k++) do_tick(15, 1'b0);
      do_tick(14, 1'b0);
      chk("x_at_5", o_obs_x, 5);
      do_tick(6, 1'b0);
      chk("retired_type", o_obs_type, 0);
      tick_until_spawn(6);

      // clear coincident with a frame tick while active
      do_tick(6, 1'b1);
      chk("clear_type", o_obs_type, 0);
      chk("clear_x", o_obs_x, 640);
      for (int k = 0; k < 9; k++) do_tick(6, 1'b0);
      chk("spawn_after_clear", m_spawn, 1);

      // reset mid-cycle while active
      do_tick(15, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midreset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) do_tick(6, 1'b0);
      chk("no_early_spawn", o_obs_type, 0);
      do_tick(6, 1'b0);
      chk("spawn_after_midreset", m_spawn, 1);

      // steer the LFSR so the next spawn draws raw code 110
      for (int k = 0; k < 60 && m_x >= 15; k++) do_tick(15, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         if (spawn_bits_after_retire(m_lfsr) == 3'b110) begin
            do_tick(15, 1'b0);
            found = 1'b1;
         end else begin
            do_tick(0, 1'b0);
         end
      end
      chk("steer_found", found, 1);
      tick_until_spawn(6);
`ifdef OBS_RENDER_BIRDS_EN
      chk("bird_type", o_obs_type, 3'b110);
      chk("bird_y", o_obs_y, 344);
`else
      chk("bird_remap_type", o_obs_type, 3'b010);
      chk("bird_remap_y", o_obs_y, 368);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
